// File: rtl/icache_axi_refill_ctrl.sv
// I-cache line refill over AXI4 read channels: one outstanding AR burst,
// beats assembled into a line buffer and returned as a single-cycle rtrn pulse.
module icache_axi_refill_ctrl #(
  parameter int unsigned LineWidth  = 128,
  parameter int unsigned PlenWidth  = 56,
  parameter int unsigned TidWidth   = 2,
  parameter int unsigned AxiIdWidth = 4,
  parameter int unsigned RdId       = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  req_i,
  input  logic [PlenWidth-1:0]  req_paddr_i,
  input  logic                  req_nc_i,
  input  logic [TidWidth-1:0]   req_tid_i,
  output logic                  ack_o,
  output logic                  ar_valid_o,
  input  logic                  ar_ready_i,
  output logic [63:0]           ar_addr_o,
  output logic [7:0]            ar_len_o,
  output logic [2:0]            ar_size_o,
  output logic [AxiIdWidth-1:0] ar_id_o,
  input  logic                  r_valid_i,
  output logic                  r_ready_o,
  input  logic [63:0]           r_data_i,
  input  logic                  r_last_i,
  input  logic [AxiIdWidth-1:0] r_id_i,
  input  logic [1:0]            r_resp_i,
  output logic                  rtrn_vld_o,
  output logic [LineWidth-1:0]  rtrn_data_o,
  output logic [TidWidth-1:0]   rtrn_tid_o,
  output logic                  rtrn_err_o,
  output logic                  busy_o
);

  localparam int unsigned Words = LineWidth / 64;
  localparam int unsigned OffW  = $clog2(LineWidth / 8);
  localparam int unsigned CntW  = $clog2(Words + 1);

  typedef enum logic [1:0] {IDLE, AR, RDATA, RTRN} state_e;

  state_e                state_q;
  logic                  nc_q;
  logic [TidWidth-1:0]   tid_q;
  logic                  drop_q;
  logic                  err_q;
  logic [CntW-1:0]       cnt_q;
  logic [LineWidth-1:0]  line_q;

  logic                  beat_c;
  logic                  over_c;
  logic                  drop_c;
  logic                  err_c;
  logic [LineWidth-1:0]  line_c;
  logic [63:0]           addr_c;

  // Acceptance is combinational so a request is taken in the cycle it appears.
  assign ack_o = (state_q == IDLE) && req_i && !rst_i;

  // Beat qualification, line merge and AR address alignment.
  always_comb begin
    beat_c = (state_q == RDATA) && r_valid_i && (r_id_i == AxiIdWidth'(RdId));
    over_c = 32'(cnt_q) >= (nc_q ? 32'd1 : Words);
    drop_c = drop_q | flush_i;
    err_c  = err_q | (beat_c & ((r_resp_i != 2'b00) | over_c));
    line_c = line_q;
    if (beat_c && !over_c) begin
      for (int unsigned w = 0; w < Words; w++) begin
        if (w == 32'(cnt_q)) line_c[w*64 +: 64] = r_data_i;
      end
    end
    addr_c = 64'(req_paddr_i) &
             (req_nc_i ? ~64'h7 : ~((64'd1 << OffW) - 64'd1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      nc_q        <= 1'b0;
      tid_q       <= '0;
      drop_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      line_q      <= '0;
      ar_valid_o  <= 1'b0;
      ar_addr_o   <= '0;
      ar_len_o    <= '0;
      ar_size_o   <= 3'd3;
      ar_id_o     <= '0;
      r_ready_o   <= 1'b0;
      rtrn_vld_o  <= 1'b0;
      rtrn_data_o <= '0;
      rtrn_tid_o  <= '0;
      rtrn_err_o  <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i) begin
            nc_q       <= req_nc_i;
            tid_q      <= req_tid_i;
            drop_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            line_q     <= '0;
            ar_valid_o <= 1'b1;
            ar_addr_o  <= addr_c;
            ar_len_o   <= req_nc_i ? 8'd0 : 8'(Words - 1);
            ar_size_o  <= 3'd3;
            ar_id_o    <= AxiIdWidth'(RdId);
            busy_o     <= 1'b1;
            state_q    <= AR;
          end
        end
        AR: begin
          drop_q <= drop_c;
          if (ar_ready_i) begin
            ar_valid_o <= 1'b0;
            r_ready_o  <= 1'b1;
            state_q    <= RDATA;
          end
        end
        RDATA: begin
          drop_q <= drop_c;
          if (beat_c) begin
            line_q <= line_c;
            err_q  <= err_c;
            if (32'(cnt_q) < Words) cnt_q <= cnt_q + CntW'(1);
            if (r_last_i) begin
              r_ready_o <= 1'b0;
              state_q   <= RTRN;
              // A flushed transaction leaves the return outputs untouched.
              if (!drop_c) begin
                rtrn_vld_o  <= 1'b1;
                rtrn_data_o <= line_c;
                rtrn_tid_o  <= tid_q;
                rtrn_err_o  <= err_c;
              end
            end
          end
        end
        RTRN: begin
          drop_q     <= drop_c;
          rtrn_vld_o <= 1'b0;
          busy_o     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_axi_refill_ctrl.sv
// Directed bench for icache_axi_refill_ctrl: a vector table of full refill
// transactions plus hand sequences for stray ids, overflow, flush and reset.
module tb_icache_axi_refill_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         flush_i;
  logic         req_i;
  logic [55:0]  req_paddr_i;
  logic         req_nc_i;
  logic [1:0]   req_tid_i;
  logic         ack_o;
  logic         ar_valid_o;
  logic         ar_ready_i;
  logic [63:0]  ar_addr_o;
  logic [7:0]   ar_len_o;
  logic [2:0]   ar_size_o;
  logic [3:0]   ar_id_o;
  logic         r_valid_i;
  logic         r_ready_o;
  logic [63:0]  r_data_i;
  logic         r_last_i;
  logic [3:0]   r_id_i;
  logic [1:0]   r_resp_i;
  logic         rtrn_vld_o;
  logic [127:0] rtrn_data_o;
  logic [1:0]   rtrn_tid_o;
  logic         rtrn_err_o;
  logic         busy_o;

  int nchecks = 0;
  int nerrors = 0;

  icache_axi_refill_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .req_i       (req_i),
    .req_paddr_i (req_paddr_i),
    .req_nc_i    (req_nc_i),
    .req_tid_i   (req_tid_i),
    .ack_o       (ack_o),
    .ar_valid_o  (ar_valid_o),
    .ar_ready_i  (ar_ready_i),
    .ar_addr_o   (ar_addr_o),
    .ar_len_o    (ar_len_o),
    .ar_size_o   (ar_size_o),
    .ar_id_o     (ar_id_o),
    .r_valid_i   (r_valid_i),
    .r_ready_o   (r_ready_o),
    .r_data_i    (r_data_i),
    .r_last_i    (r_last_i),
    .r_id_i      (r_id_i),
    .r_resp_i    (r_resp_i),
    .rtrn_vld_o  (rtrn_vld_o),
    .rtrn_data_o (rtrn_data_o),
    .rtrn_tid_o  (rtrn_tid_o),
    .rtrn_err_o  (rtrn_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [55:0]  paddr;
    logic         nc;
    logic [1:0]   tid;
    int           ar_wait;
    int           nbeats;
    logic [63:0]  d0;
    logic [63:0]  d1;
    logic [1:0]   resp0;
    logic [1:0]   resp1;
    logic [63:0]  e_addr;
    logic [7:0]   e_len;
    logic [127:0] e_data;
    logic         e_err;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Full transaction from IDLE: checks ack, AR payload under backpressure,
  // the one-cycle return and the held values afterwards.
  task automatic run_vec(input vec_t v);
    req_i = 1'b1; req_paddr_i = v.paddr; req_nc_i = v.nc; req_tid_i = v.tid;
    #1;
    chk("ack", ack_o, 1);
    next_cycle();
    req_i = 1'b0;
    chk("ar_valid", ar_valid_o, 1);
    chk("ar_addr", ar_addr_o, v.e_addr);
    chk("ar_len", ar_len_o, v.e_len);
    chk("ar_size", ar_size_o, 3);
    chk("ar_id", ar_id_o, 0);
    chk("busy", busy_o, 1);
    for (int i = 0; i < v.ar_wait; i++) begin
      ar_ready_i = 1'b0; req_i = 1'b1;
      #1;
      chk("ack_busy", ack_o, 0);
      chk("ar_valid_bp", ar_valid_o, 1);
      chk("ar_addr_bp", ar_addr_o, v.e_addr);
      chk("ar_len_bp", ar_len_o, v.e_len);
      next_cycle();
    end
    req_i = 1'b0; ar_ready_i = 1'b1;
    next_cycle();
    ar_ready_i = 1'b0;
    chk("r_ready", r_ready_o, 1);
    chk("ar_valid_done", ar_valid_o, 0);
    for (int b = 0; b < v.nbeats; b++) begin
      r_valid_i = 1'b1; r_id_i = 4'd0;
      r_data_i  = (b == 0) ? v.d0 : v.d1;
      r_resp_i  = (b == 0) ? v.resp0 : v.resp1;
      r_last_i  = (b == v.nbeats - 1);
      next_cycle();
    end
    r_valid_i = 1'b0; r_last_i = 1'b0; r_resp_i = 2'd0;
    chk("rtrn_vld", rtrn_vld_o, 1);
    chk("rtrn_data", rtrn_data_o, v.e_data);
    chk("rtrn_tid", rtrn_tid_o, v.tid);
    chk("rtrn_err", rtrn_err_o, v.e_err);
    chk("r_ready_rtrn", r_ready_o, 0);
    next_cycle();
    chk("rtrn_vld_off", rtrn_vld_o, 0);
    chk("busy_off", busy_o, 0);
    chk("rtrn_data_hold", rtrn_data_o, v.e_data);
  endtask

  // Issue a request and complete AR immediately; returns in RDATA.
  task automatic start_req(input logic [55:0] paddr, input logic nc, input logic [1:0] tid);
    req_i = 1'b1; req_paddr_i = paddr; req_nc_i = nc; req_tid_i = tid;
    next_cycle();
    req_i = 1'b0; ar_ready_i = 1'b1;
    next_cycle();
    ar_ready_i = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] data, input logic last,
                           input logic [3:0] id, input logic [1:0] resp);
    r_valid_i = 1'b1; r_data_i = data; r_last_i = last; r_id_i = id; r_resp_i = resp;
    next_cycle();
    r_valid_i = 1'b0; r_last_i = 1'b0; r_id_i = 4'd0; r_resp_i = 2'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{56'h8000_0014, 1'b0, 2'd1, 0, 2, 64'hA, 64'hB, 2'd0, 2'd0,
                64'h8000_0010, 8'd1, {64'hB, 64'hA}, 1'b0};
    vecs[1] = '{56'h1000_0004, 1'b1, 2'd2, 0, 1, 64'hC, 64'h0, 2'd0, 2'd0,
                64'h1000_0000, 8'd0, {64'h0, 64'hC}, 1'b0};
    vecs[2] = '{56'h1234_567F, 1'b0, 2'd3, 5, 2, 64'h1111, 64'h2222, 2'd0, 2'd0,
                64'h1234_5670, 8'd1, {64'h2222, 64'h1111}, 1'b0};
    vecs[3] = '{56'h40, 1'b0, 2'd0, 2, 1, 64'hDEAD, 64'h0, 2'd2, 2'd0,
                64'h40, 8'd1, {64'h0, 64'hDEAD}, 1'b1};
    vecs[4] = '{56'hFF_FFFF_FFFF_FFFF, 1'b0, 2'd1, 1, 2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                2'd0, 2'd1, 64'h00FF_FFFF_FFFF_FFF0, 8'd1,
                {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b1};

    rst_i = 1'b1; flush_i = 1'b0; req_i = 1'b0; req_paddr_i = '0; req_nc_i = 1'b0;
    req_tid_i = '0; ar_ready_i = 1'b0; r_valid_i = 1'b0; r_data_i = '0;
    r_last_i = 1'b0; r_id_i = '0; r_resp_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ar_valid", ar_valid_o, 0);
    chk("rst_ar_size", ar_size_o, 3);
    chk("rst_r_ready", r_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_rtrn_data", rtrn_data_o, 0);
    rst_i = 1'b0;
    next_cycle();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Stray id between matching beats is ignored; bad resp is sticky.
    start_req(56'h100, 1'b0, 2'd2);
    send_beat(64'h5, 1'b0, 4'd0, 2'd2);
    send_beat(64'hBAD, 1'b1, 4'd3, 2'd0);
    chk("stray_stay_rdata", r_ready_o, 1);
    chk("stray_no_vld", rtrn_vld_o, 0);
    send_beat(64'h6, 1'b1, 4'd0, 2'd0);
    chk("stray_vld", rtrn_vld_o, 1);
    chk("stray_data", rtrn_data_o, {64'h6, 64'h5});
    chk("stray_err", rtrn_err_o, 1);
    chk("stray_tid", rtrn_tid_o, 2);
    next_cycle();

    // Extra beats past the line are dropped and flag an error.
    start_req(56'h200, 1'b0, 2'd1);
    send_beat(64'h1, 1'b0, 4'd0, 2'd0);
    send_beat(64'h2, 1'b0, 4'd0, 2'd0);
    send_beat(64'h3, 1'b0, 4'd0, 2'd0);
    send_beat(64'h4, 1'b1, 4'd0, 2'd0);
    chk("ovf_vld", rtrn_vld_o, 1);
    chk("ovf_data", rtrn_data_o, {64'h2, 64'h1});
    chk("ovf_err", rtrn_err_o, 1);
    next_cycle();

    // Flush during RDATA: burst drains, return suppressed, outputs held.
    start_req(56'h300, 1'b0, 2'd3);
    flush_i = 1'b1;
    next_cycle();
    flush_i = 1'b0;
    chk("flush_r_ready", r_ready_o, 1);
    send_beat(64'h7, 1'b0, 4'd0, 2'd0);
    send_beat(64'h8, 1'b1, 4'd0, 2'd0);
    chk("flush_no_vld", rtrn_vld_o, 0);
    chk("flush_busy", busy_o, 1);
    chk("flush_data_hold", rtrn_data_o, {64'h2, 64'h1});
    chk("flush_tid_hold", rtrn_tid_o, 1);
    next_cycle();
    chk("flush_idle_vld", rtrn_vld_o, 0);
    chk("flush_idle_busy", busy_o, 0);
    run_vec(vecs[0]);

    // Asynchronous reset mid-burst abandons the transaction.
    start_req(56'h400, 1'b0, 2'd2);
    send_beat(64'h9, 1'b0, 4'd0, 2'd0);
    rst_i = 1'b1; req_i = 1'b1;
    #1;
    chk("mrst_ack", ack_o, 0);
    chk("mrst_ar_valid", ar_valid_o, 0);
    chk("mrst_r_ready", r_ready_o, 0);
    chk("mrst_rtrn_vld", rtrn_vld_o, 0);
    chk("mrst_busy", busy_o, 0);
    chk("mrst_ar_addr", ar_addr_o, 0);
    chk("mrst_ar_len", ar_len_o, 0);
    chk("mrst_ar_size", ar_size_o, 3);
    chk("mrst_ar_id", ar_id_o, 0);
    chk("mrst_rtrn_data", rtrn_data_o, 0);
    chk("mrst_rtrn_tid", rtrn_tid_o, 0);
    chk("mrst_rtrn_err", rtrn_err_o, 0);
    next_cycle();
    rst_i = 1'b0; req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_r_ready", r_ready_o, 0);
      send_beat(64'hA0 + 64'(i), 1'b1, 4'd0, 2'd0);
      chk("post_rst_no_vld", rtrn_vld_o, 0);
      chk("post_rst_busy", busy_o, 0);
    end
    run_vec(vecs[2]);

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule

// File: doc/icache_axi_refill_ctrl.md
ICACHE_AXI_REFILL_CTRL -- requirements
Module: icache_axi_refill_ctrl

Interface
REQ-001 SHALL have parameters: LineWidth, 128, I$ line bits (multiple of 64; Words = LineWidth/64); PlenWidth, 56, physical address bits; TidWidth, 2, refill transaction id bits; AxiIdWidth, 4, AXI id bits; RdId, 0, AXI id driven on AR.
REQ-002 SHALL have ports: clk_i  in  1  clock, rising edge; all state on this clock only.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 flush_i  in  1  discard outstanding refill result.
REQ-005 req_i / req_paddr_i / req_nc_i / req_tid_i  in  1/PlenWidth/1/TidWidth  refill request, address, non-cacheable, tid.
REQ-006 ack_o  out  1  request accepted this cycle.
REQ-007 ar_valid_o / ar_ready_i  out/in  1/1  AR handshake; ar_addr_o out 64; ar_len_o out 8; ar_size_o out 3; ar_id_o out AxiIdWidth.
REQ-008 r_valid_i in 1; r_ready_o out 1; r_data_i in 64; r_last_i in 1; r_id_i in AxiIdWidth; r_resp_i in 2.
REQ-009 rtrn_vld_o out 1; rtrn_data_o out LineWidth; rtrn_tid_o out TidWidth; rtrn_err_o out 1; busy_o out 1 (state != IDLE).

Function
REQ-010 SHALL implement FSM IDLE, AR, RDATA, RTRN; one outstanding transaction max.
REQ-011 IDLE: ack_o = req_i (combinational); on req_i capture paddr/nc/tid, clear line buffer and error flag, go AR; ack_o SHALL be 0 in all other states.
REQ-012 AR: ar_valid_o=1, payload stable until ar_ready_i; on ar_valid_o & ar_ready_i go RDATA; ar_valid_o rises the cycle after ack_o.
REQ-013 Address: cacheable -> paddr with low log2(LineWidth/8) bits zeroed; nc -> paddr with low 3 bits zeroed; zero-extended to 64.
REQ-014 ar_len_o = Words-1 cacheable, 0 nc; ar_size_o = 3; ar_id_o = RdId.
REQ-015 RDATA: r_ready_o=1 (0 in all other states); beat accepted on r_valid_i & r_ready_o.
REQ-016 Beats with r_id_i != RdId SHALL be accepted and dropped (no buffer, counter or state change).
REQ-017 Matching beat k (k = beat counter, 0-based) SHALL be written to word k of line buffer; nc beat to word 0, other words remain 0.
REQ-018 Beats beyond Words-1 without r_last_i SHALL be dropped and set error flag; counter saturates.
REQ-019 r_resp_i != 0 on any matching beat SHALL set sticky error flag.
REQ-020 Matching beat with r_last_i -> RTRN next cycle; early last leaves unfilled words 0.
REQ-021 RTRN: rtrn_vld_o=1 for exactly one cycle with registered data, captured tid, error flag; then IDLE; new req_i may be acked in the following IDLE cycle.
REQ-022 rtrn_data_o/tid/err SHALL hold last values while rtrn_vld_o=0.
REQ-023 flush_i in AR/RDATA/RTRN SHALL set drop flag; AXI transaction still completes; rtrn_vld_o suppressed for that transaction; flush_i in IDLE has no effect; drop flag cleared on next ack.
REQ-024 Minimum latency: ack cycle 0, ar_valid cycle 1, ar_ready same cycle, single-beat R in cycle 2, rtrn_vld cycle 3.

Reset
REQ-025 On rst_i (any state, asynchronous): FSM=IDLE; ack_o, ar_valid_o, r_ready_o, rtrn_vld_o, rtrn_err_o, busy_o = 0; ar_addr_o, ar_len_o, ar_id_o, rtrn_data_o, rtrn_tid_o, counter, drop/error flags = 0; ar_size_o = 3.
REQ-026 Reset mid-transaction SHALL abandon it with no rtrn_vld_o afterward; R beats arriving in IDLE after reset are ignored (r_ready_o=0).

Verification
REQ-027 Cacheable: req paddr=0x8000_0014, tid=1 -> ar_addr=0x8000_0010, len=1, size=3, id=0; beats 0xA, 0xB(last) -> one-cycle rtrn_vld, data={0xB,0xA}, tid=1, err=0.
REQ-028 NC: req nc=1, paddr=0x1000_0004 -> ar_addr=0x1000_0000, len=0; beat 0xC(last) -> data={0,0xC}.
REQ-029 Backpressure: ar_ready low 5 cycles -> ar_valid and payload stable all 5; ack_o=0 for req_i during busy.
REQ-030 Error/id: beat0 resp=2, stray beat id=3 between beats -> stray dropped, rtrn_err=1, data words correct.
REQ-031 Flush in RDATA -> burst completes, no rtrn_vld, next req acked normally and returns correctly.
REQ-032 rst_i pulse during RDATA -> all outputs at reset values same cycle, FSM IDLE, later R beats ignored.
